// File: rtl/team_01_keypad_scanner.sv
// team_01_keypad_scanner
// Scan controller for the team_01 4x4 matrix keypad. Drives one column low at
// a time, samples the synchronized row inputs, debounces a single key press,
// hands its ASCII code to the consumer over valid/ready, debounces the
// release, and rejects multi-row (ghost) samples.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   en           scan enable; low returns everything to IDLE and clears outputs
//   rows_i[3:0]  row inputs, active-high, asynchronous to clk
//   cols_o[3:0]  column drive, active-low one-hot, 4'hF when idle
//   key_code_o   ASCII code of the last accepted key
//   key_valid_o  key_code_o holds an unconsumed key
//   key_ready_i  consumer accepts the key on this cycle
//   held_o       a debounced key is currently held down
//   overflow_o   sticky: a key was dropped because the previous one was pending

module team_01_keypad_scanner #(
    parameter int SCAN_CYCLES    = 4,
    parameter int DEBOUNCE_SCANS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] rows_i,
    output logic [3:0] cols_o,
    output logic [7:0] key_code_o,
    output logic       key_valid_o,
    input  logic       key_ready_i,
    output logic       held_o,
    output logic       overflow_o
);

    localparam int CW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int MW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;

    localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
    localparam logic [MW-1:0] MATCH_LAST = MW'(DEBOUNCE_SCANS - 1);
    localparam logic [MW-1:0] MATCH_ONE  = MW'(1);
    localparam logic [MW-1:0] MATCH_ZERO = MW'(0);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SCAN     = 2'd1,
        ST_DEBOUNCE = 2'd2,
        ST_HELD     = 2'd3
    } state_t;

    // Keypad legend lookup; row_bits is the one-hot candidate row pattern.
    function automatic logic [7:0] key_ascii(input logic [3:0] row_bits, input logic [1:0] col);
        logic [7:0] code;
        case ({row_bits, col})
            6'b0001_00: code = 8'h31; // '1'
            6'b0001_01: code = 8'h32; // '2'
            6'b0001_10: code = 8'h33; // '3'
            6'b0001_11: code = 8'h41; // 'A'
            6'b0010_00: code = 8'h34; // '4'
            6'b0010_01: code = 8'h35; // '5'
            6'b0010_10: code = 8'h36; // '6'
            6'b0010_11: code = 8'h42; // 'B'
            6'b0100_00: code = 8'h37; // '7'
            6'b0100_01: code = 8'h38; // '8'
            6'b0100_10: code = 8'h39; // '9'
            6'b0100_11: code = 8'h43; // 'C'
            6'b1000_00: code = 8'h2A; // '*'
            6'b1000_01: code = 8'h30; // '0'
            6'b1000_10: code = 8'h23; // '#'
            6'b1000_11: code = 8'h44; // 'D'
            default:    code = 8'h00;
        endcase
        return code;
    endfunction

    logic [3:0]    rows_meta_r;
    logic [3:0]    rows_sync_r;
    state_t        state_r, state_s;
    logic [1:0]    col_r, col_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [MW-1:0] match_r, match_s;
    logic [3:0]    cand_r, cand_s;
    logic [7:0]    code_s;
    logic          valid_s;
    logic          ovf_s;
    logic          held_s;
    logic [3:0]    cols_s;
    logic          accept_s;
    logic          sample_s;

    // Two-flop synchronizer for the asynchronous row inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rows_meta_r <= 4'h0;
            rows_sync_r <= 4'h0;
        end else begin
            rows_meta_r <= rows_i;
            rows_sync_r <= rows_meta_r;
        end
    end

    // Next-state, counters and next output values.
    always_comb begin
        state_s  = state_r;
        col_s    = col_r;
        cnt_s    = cnt_r;
        match_s  = match_r;
        cand_s   = cand_r;
        code_s   = key_code_o;
        ovf_s    = overflow_o;
        accept_s = 1'b0;
        sample_s = (cnt_r == CNT_LAST);

        // A transfer this cycle empties the holding register unless refilled below.
        if (key_valid_o && key_ready_i) begin
            valid_s = 1'b0;
        end else begin
            valid_s = key_valid_o;
        end

        if (!en) begin
            state_s = ST_IDLE;
            col_s   = 2'd0;
            cnt_s   = CNT_ZERO;
            match_s = MATCH_ZERO;
            cand_s  = 4'h0;
            code_s  = 8'h00;
            valid_s = 1'b0;
            ovf_s   = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_SCAN;
                    col_s   = 2'd0;
                    cnt_s   = CNT_ZERO;
                    match_s = MATCH_ZERO;
                end
                ST_SCAN: begin
                    if (sample_s) begin
                        cnt_s = CNT_ZERO;
                        // Only a single-row hit is a candidate; 0 or 2+ rows move on.
                        if ($onehot(rows_sync_r)) begin
                            cand_s  = rows_sync_r;
                            match_s = MATCH_ZERO;
                            state_s = ST_DEBOUNCE;
                        end else begin
                            col_s = col_r + 2'd1;
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (sample_s) begin
                        cnt_s = CNT_ZERO;
                        if (rows_sync_r == cand_r) begin
                            if (match_r == MATCH_LAST) begin
                                accept_s = 1'b1;
                                match_s  = MATCH_ZERO;
                                state_s  = ST_HELD;
                            end else begin
                                match_s = match_r + MATCH_ONE;
                            end
                        end else begin
                            match_s = MATCH_ZERO;
                            col_s   = col_r + 2'd1;
                            state_s = ST_SCAN;
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_HELD: begin
                    if (sample_s) begin
                        cnt_s = CNT_ZERO;
                        // match_r counts consecutive all-zero samples here.
                        if (rows_sync_r == 4'h0) begin
                            if (match_r == MATCH_LAST) begin
                                match_s = MATCH_ZERO;
                                col_s   = col_r + 2'd1;
                                state_s = ST_SCAN;
                            end else begin
                                match_s = match_r + MATCH_ONE;
                            end
                        end else begin
                            match_s = MATCH_ZERO;
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    col_s   = 2'd0;
                    cnt_s   = CNT_ZERO;
                    match_s = MATCH_ZERO;
                end
            endcase

            // Load the key if the slot is free or is being emptied this same cycle.
            if (accept_s) begin
                if (!key_valid_o || key_ready_i) begin
                    code_s  = key_ascii(cand_r, col_r);
                    valid_s = 1'b1;
                end else begin
                    ovf_s = 1'b1;
                end
            end else begin
                ovf_s = overflow_o;
            end
        end

        held_s = (state_s == ST_HELD);
        if (state_s == ST_IDLE) begin
            cols_s = 4'hF;
        end else begin
            cols_s = ~(4'b0001 << col_s);
        end
    end

    // FSM state and scan bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            col_r   <= 2'd0;
            cnt_r   <= CNT_ZERO;
            match_r <= MATCH_ZERO;
            cand_r  <= 4'h0;
        end else begin
            state_r <= state_s;
            col_r   <= col_s;
            cnt_r   <= cnt_s;
            match_r <= match_s;
            cand_r  <= cand_s;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cols_o      <= 4'hF;
            key_code_o  <= 8'h00;
            key_valid_o <= 1'b0;
            held_o      <= 1'b0;
            overflow_o  <= 1'b0;
        end else begin
            cols_o      <= cols_s;
            key_code_o  <= code_s;
            key_valid_o <= valid_s;
            held_o      <= held_s;
            overflow_o  <= ovf_s;
        end
    end

endmodule

// File: tb/tb_team_01_keypad_scanner.sv
// Self-checking bench for team_01_keypad_scanner (SCAN_CYCLES=4, DEBOUNCE_SCANS=2).
// A keypad matrix model turns the set of pressed keys plus the driven column
// into row levels; expected key codes are queued when a key is pressed and a
// monitor compares them at every valid/ready transfer.

module tb_team_01_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        key_ready_i = 1'b0;
    logic [15:0] pressed = 16'h0;
    logic        override_en = 1'b0;
    logic [3:0]  override_rows = 4'h0;
    logic [3:0]  rows_i;
    logic [3:0]  cols_o;
    logic [7:0]  key_code_o;
    logic        key_valid_o;
    logic        held_o;
    logic        overflow_o;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [7:0]  exp_q[$];
    string       keys = "123A456B789C*0#D";
    bit          rand_ready = 1'b0;

    team_01_keypad_scanner #(.SCAN_CYCLES(4), .DEBOUNCE_SCANS(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .rows_i      (rows_i),
        .cols_o      (cols_o),
        .key_code_o  (key_code_o),
        .key_valid_o (key_valid_o),
        .key_ready_i (key_ready_i),
        .held_o      (held_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk = ~clk;

    // Matrix: row r reads high when a pressed key in row r sits on a driven (low) column.
    function automatic logic [3:0] keypad(input logic [15:0] p, input logic [3:0] cols);
        logic [3:0] v;
        v = 4'h0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (p[r*4+c] && !cols[c]) v[r] = 1'b1;
        return v;
    endfunction

    assign rows_i = override_en ? override_rows : keypad(pressed, cols_o);

    function automatic logic [7:0] ascii_of(input int r, input int c);
        return keys[r*4+c];
    endfunction

    function automatic logic [15:0] key_bit(input int r, input int c);
        return 16'd1 << (r*4+c);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) key_ready_i = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_held(input logic lvl, input int bound, input string name);
        int n;
        n = 0;
        while (held_o !== lvl && n < bound) begin
            tick();
            n++;
        end
        check(name, {31'h0, held_o}, {31'h0, lvl});
    endtask

    // Wait until the scan just switched onto column pattern v.
    task automatic wait_col(input logic [3:0] v, input int bound, input string name);
        logic [3:0] prev;
        int n;
        n = 0;
        prev = cols_o;
        tick();
        while (!(cols_o == v && prev != v) && n < bound) begin
            prev = cols_o;
            tick();
            n++;
        end
        check(name, {28'h0, cols_o}, {28'h0, v});
    endtask

    // Scoreboard monitor: every transfer must match the oldest expected key.
    always @(negedge clk) begin
        if (!rst && key_valid_o && key_ready_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_key: got %0h expected none", key_code_o);
            end else begin
                check("key_code", {24'h0, key_code_o}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n_valid;
        logic [7:0] code_seen;
        int order[16];
        int tmp;
        int j;
        int n;

        // Reset values
        tick();
        tick();
        check("rst_cols", {28'h0, cols_o}, 32'hF);
        check("rst_outs", {20'h0, key_code_o, key_valid_o, held_o, overflow_o}, 32'h0);
        rst = 1'b0;
        tick();
        check("idle_cols", {28'h0, cols_o}, 32'hF);

        // Idle scan: each column for 4 cycles, wrapping back to c0
        en = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            logic [3:0] ec;
            tick();
            case (((i - 1) / 4) % 4)
                0: ec = 4'hE;
                1: ec = 4'hD;
                2: ec = 4'hB;
                default: ec = 4'h7;
            endcase
            check("idle_scan", {28'h0, cols_o}, {28'h0, ec});
        end
        check("idle_quiet", {20'h0, key_code_o, key_valid_o, held_o, overflow_o}, 32'h0);

        // Press '1' as column 0 is driven; consumer not ready
        exp_q.push_back(ascii_of(0, 0));
        pressed = key_bit(0, 0);
        lat = 0;
        while (!key_valid_o && lat < 30) begin
            tick();
            lat++;
        end
        check("press_latency", lat, 12);
        check("press_code", {24'h0, key_code_o}, 32'h31);
        check("press_held", {31'h0, held_o}, 32'h1);
        repeat (8) tick();
        check("held_frozen_col", {28'h0, cols_o}, 32'hE);
        check("held_still", {31'h0, held_o}, 32'h1);

        // Release: two all-zero samples end HELD, scan resumes at c1
        pressed = 16'h0;
        lat = 0;
        while (held_o && lat < 20) begin
            tick();
            lat++;
        end
        check("release_latency", lat, 8);
        check("release_col", {28'h0, cols_o}, 32'hD);

        // '#' while '1' is still pending: dropped with overflow
        check("ovf_before", {31'h0, overflow_o}, 32'h0);
        pressed = key_bit(3, 2);
        wait_held(1'b1, 60, "ovf_press_held");
        check("ovf_set", {31'h0, overflow_o}, 32'h1);
        check("ovf_code_kept", {24'h0, key_code_o}, 32'h31);
        check("ovf_valid", {31'h0, key_valid_o}, 32'h1);

        // en low clears everything, including the pending key
        en = 1'b0;
        tick();
        exp_q.delete();
        check("en_low_cols", {28'h0, cols_o}, 32'hF);
        check("en_low_outs", {20'h0, key_code_o, key_valid_o, held_o, overflow_o}, 32'h0);
        pressed = 16'h0;
        en = 1'b1;
        tick();
        check("en_high_cols", {28'h0, cols_o}, 32'hE);

        // Glitch on c2: candidate found, one bad sample, scan moves to c3
        wait_col(4'hB, 40, "wait_c2");
        override_en = 1'b1;
        override_rows = 4'h4;
        repeat (4) tick();
        check("glitch_debounce_col", {28'h0, cols_o}, 32'hB);
        override_rows = 4'h0;
        repeat (4) tick();
        check("glitch_advance_col", {28'h0, cols_o}, 32'h7);
        check("glitch_no_key", {31'h0, key_valid_o}, 32'h0);
        override_en = 1'b0;

        // Stable '9' on c2, then a single ready pulse
        exp_q.push_back(ascii_of(2, 2));
        pressed = key_bit(2, 2);
        wait_held(1'b1, 60, "nine_held");
        check("nine_code", {24'h0, key_code_o}, 32'h39);
        key_ready_i = 1'b1;
        tick();
        check("valid_drop_after_ready", {31'h0, key_valid_o}, 32'h0);
        key_ready_i = 1'b0;
        pressed = 16'h0;
        wait_held(1'b0, 20, "nine_release");

        // Ghost: two rows on c1 are skipped
        wait_col(4'hD, 40, "wait_c1");
        override_en = 1'b1;
        override_rows = 4'h3;
        repeat (4) tick();
        check("ghost_advance_col", {28'h0, cols_o}, 32'hB);
        override_en = 1'b0;
        repeat (20) tick();
        check("ghost_no_key", {30'h0, key_valid_o, held_o}, 32'h0);

        // '0' with ready held high: valid for exactly one cycle
        key_ready_i = 1'b1;
        exp_q.push_back(ascii_of(3, 1));
        pressed = key_bit(3, 1);
        n_valid = 0;
        code_seen = 8'h00;
        for (int t = 0; t < 60; t++) begin
            tick();
            if (key_valid_o) begin
                n_valid++;
                code_seen = key_code_o;
            end
        end
        check("zero_valid_cycles", n_valid, 1);
        check("zero_code", {24'h0, code_seen}, 32'h30);
        check("zero_held", {31'h0, held_o}, 32'h1);
        pressed = 16'h0;
        wait_held(1'b0, 20, "zero_release");
        key_ready_i = 1'b0;

        // Reset in the middle of debouncing '5'
        pressed = key_bit(1, 1);
        wait_col(4'hD, 40, "wait_c1_rst");
        repeat (6) tick();
        rst = 1'b1;
        #1;
        check("midrst_cols", {28'h0, cols_o}, 32'hF);
        check("midrst_outs", {20'h0, key_code_o, key_valid_o, held_o, overflow_o}, 32'h0);
        pressed = 16'h0;
        repeat (2) tick();
        rst = 1'b0;
        n_valid = 0;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (key_valid_o) n_valid++;
        end
        check("midrst_no_key", n_valid, 0);

        // Randomized: every key once in shuffled order, ghosts interleaved, random ready
        for (int i = 0; i < 16; i++) order[i] = i;
        for (int i = 15; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            tmp = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        rand_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k % 4 == 0) begin
                int gc, r1, r2;
                gc = int'($urandom_range(0, 3));
                r1 = int'($urandom_range(0, 3));
                r2 = (r1 + 1 + int'($urandom_range(0, 2))) % 4;
                pressed = key_bit(r1, gc) | key_bit(r2, gc);
                repeat (40) tick();
                pressed = 16'h0;
                repeat (8) tick();
            end
            repeat ($urandom_range(0, 15)) tick();
            exp_q.push_back(ascii_of(order[k] / 4, order[k] % 4));
            pressed = key_bit(order[k] / 4, order[k] % 4);
            wait_held(1'b1, 60, "rand_press");
            repeat ($urandom_range(0, 10)) tick();
            pressed = 16'h0;
            wait_held(1'b0, 30, "rand_release");
            n = 0;
            while (exp_q.size() != 0 && n < 200) begin
                tick();
                n++;
            end
            check("rand_drain", exp_q.size(), 0);
        end
        rand_ready = 1'b0;
        key_ready_i = 1'b0;
        tick();
        check("final_overflow", {31'h0, overflow_o}, 32'h0);
        check("final_queue", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
